// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - 32-bit DDS phase accumulator; optional portamento glide via PHASE_GLIDE_EN.
module dds_phase_acc #(
  parameter logic [31:0] PHASE_OFFSET = 32'h0000_0000,
  parameter int          GLIDE_SHIFT  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [31:0] FTW_IN,
  input  logic        FTW_VALID,
  output logic        FTW_READY,
  input  logic        SYNC,
  output logic [31:0] DDS,
  output logic        WRAP
);

  if (GLIDE_SHIFT < 1 || GLIDE_SHIFT > 16) begin : g_bad_glide_shift
    $error("GLIDE_SHIFT must be in 1..16");
  end

  logic [31:0] r_dds;
  logic        r_wrap;
  logic [31:0] r_cur_ftw;
  logic [32:0] w_sum;
  logic        w_accept;

  // The increment always uses the pre-update cur_ftw; new tuning applies one tick later.
  assign w_sum    = {1'b0, r_dds} + {1'b0, r_cur_ftw};
  assign w_accept = FTW_VALID && FTW_READY;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_dds  <= PHASE_OFFSET;
      r_wrap <= 1'b0;
    end else if (SYNC) begin
      r_dds  <= PHASE_OFFSET;
      r_wrap <= 1'b0;
    end else if (ENABLE) begin
      r_dds  <= w_sum[31:0];
      r_wrap <= w_sum[32];
    end else begin
      r_wrap <= 1'b0;
    end
  end

`ifdef PHASE_GLIDE_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GLIDE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_tgt_ftw;
  logic [31:0]        w_tgt_next;
  logic [31:0]        w_cur_next;
  logic signed [32:0] w_diff;
  logic signed [32:0] w_step;

  // Signed 33-bit difference so glides downward converge as well as upward.
  assign w_diff = $signed({1'b0, r_tgt_ftw}) - $signed({1'b0, r_cur_ftw});
  assign w_step = w_diff >>> GLIDE_SHIFT;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_tgt_ftw <= 32'h0;
      r_cur_ftw <= 32'h0;
    end else begin
      r_state   <= w_state_next;
      r_tgt_ftw <= w_tgt_next;
      r_cur_ftw <= w_cur_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tgt_next   = r_tgt_ftw;
    w_cur_next   = r_cur_ftw;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_tgt_next   = FTW_IN;
          w_state_next = ST_GLIDE;
        end
      end
      ST_GLIDE: begin
        if (ENABLE) begin
          // A zero step means the remaining gap is below one slew unit: snap to target.
          if (w_step == '0) begin
            w_cur_next   = r_tgt_ftw;
            w_state_next = ST_IDLE;
          end else begin
            w_cur_next = r_cur_ftw + w_step[31:0];
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign FTW_READY = (r_state == ST_IDLE);
`else
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_cur_ftw <= 32'h0;
    end else if (w_accept) begin
      r_cur_ftw <= FTW_IN;
    end
  end

  assign FTW_READY = 1'b1;
`endif

  assign DDS  = r_dds;
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb/tb_dds_phase_acc.sv - scoreboard bench for dds_phase_acc; glide checks when PHASE_GLIDE_EN is defined.
module tb_dds_phase_acc;
  localparam logic [31:0] OFF   = 32'h8000_0000;
  localparam int          SHIFT = 2;
  localparam longint      TWO32 = 64'sh1_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        sync = 1'b0;
  logic        ftw_valid = 1'b0;
  logic [31:0] ftw_in = 32'h0;
  logic        ftw_ready;
  logic [31:0] dds;
  logic        wrap;

  always #5 clk = ~clk;

  dds_phase_acc #(
    .PHASE_OFFSET(OFF),
    .GLIDE_SHIFT (SHIFT)
  ) dut (
    .CLK      (clk),
    .RESET    (reset),
    .ENABLE   (enable),
    .FTW_IN   (ftw_in),
    .FTW_VALID(ftw_valid),
    .FTW_READY(ftw_ready),
    .SYNC     (sync),
    .DDS      (dds),
    .WRAP     (wrap)
  );

  typedef struct {
    logic [31:0] dds;
    logic        wrap;
    logic        ready;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  longint m_dds = 0;
  longint m_cur = 0;
  longint m_tgt = 0;
  bit     m_glide = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: phase as an integer modulo 2^32, glide as floor-divided fraction of the remaining gap.
  task automatic step(input bit r, input bit e, input bit s, input bit v, input logic [31:0] f);
    exp_t   x;
    longint sum;
    longint diff;
    longint den;
    longint stp;
    @(negedge clk);
    reset = r; enable = e; sync = s; ftw_valid = v; ftw_in = f;
    x.wrap = 1'b0;
    if (!r) begin
      m_dds = longint'(OFF); m_cur = 0; m_tgt = 0; m_glide = 1'b0;
    end else begin
      sum = m_dds + m_cur;
      x.wrap = e && !s && (sum >= TWO32);
      if (s) m_dds = longint'(OFF);
      else if (e) m_dds = sum % TWO32;
`ifdef PHASE_GLIDE_EN
      if (v && !m_glide) begin
        m_tgt = longint'(f);
        m_glide = 1'b1;
      end else if (m_glide && e) begin
        diff = m_tgt - m_cur;
        den = longint'(1) << SHIFT;
        stp = (diff >= 0) ? diff / den : -((-diff + den - 1) / den);
        if (stp == 0) begin
          m_cur = m_tgt;
          m_glide = 1'b0;
        end else begin
          m_cur = m_cur + stp;
        end
      end
`else
      if (v) m_cur = longint'(f);
`endif
    end
    x.dds = m_dds[31:0];
    x.ready = !m_glide;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_dds", dds, e.dds);
        check("sb_wrap", {31'h0, wrap}, {31'h0, e.wrap});
        check("sb_ready", {31'h0, ftw_ready}, {31'h0, e.ready});
      end
    end
  end

  initial begin : stimulus
    logic [31:0] prev;
    logic [31:0] seq_dds [4];
    logic        seq_wrap [4];
    int          deltas [8];
    int          wait_cycles;

    step(0, 1, 1, 1, 32'h1234_5678);
    step(0, 0, 0, 0, 32'h0);
    check("reset_dds", dds, OFF);
    check("reset_wrap", {31'h0, wrap}, 32'h0);
    check("reset_ready", {31'h0, ftw_ready}, 32'h1);

`ifdef PHASE_GLIDE_EN
    deltas = '{0, 4, 7, 9, 10, 11, 12, 13};
    step(1, 0, 0, 1, 32'd16);
    check("glide_ready_low", {31'h0, ftw_ready}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      prev = dds;
      step(1, 1, 0, 1, 32'hDEAD_BEEF);
      check("glide_delta", dds - prev, deltas[i]);
      check("glide_ready", {31'h0, ftw_ready}, (i == 7) ? 32'h1 : 32'h0);
    end
    ftw_valid = 1'b0;
    prev = dds;
    step(1, 1, 0, 0, 32'h0);
    check("glide_final_delta", dds - prev, 32'd16);
    step(1, 0, 0, 1, 32'd1000);
    step(1, 1, 0, 0, 32'h0);
    step(0, 1, 0, 0, 32'h0);
    check("glide_rst_ready", {31'h0, ftw_ready}, 32'h1);
    check("glide_rst_dds", dds, OFF);
    check("glide_rst_wrap", {31'h0, wrap}, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    check("glide_rst_cur0", dds, OFF);
`else
    seq_dds  = '{32'hC000_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
    seq_wrap = '{1'b0, 1'b1, 1'b0, 1'b0};
    step(1, 0, 0, 1, 32'h4000_0000);
    check("accept_hold_dds", dds, OFF);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 32'h0);
      check("ramp_dds", dds, seq_dds[i]);
      check("ramp_wrap", {31'h0, wrap}, {31'h0, seq_wrap[i]});
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 32'h0);
      check("idle_dds", dds, 32'h8000_0000);
      check("idle_wrap", {31'h0, wrap}, 32'h0);
    end
    step(1, 0, 0, 1, 32'h0);
    step(1, 1, 0, 1, 32'h1000_0000);
    check("same_edge_dds", dds, 32'h8000_0000);
    step(1, 1, 0, 0, 32'h0);
    check("next_edge_dds", dds, 32'h9000_0000);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 32'h0);
    check("pre_sync_dds", dds, 32'hF000_0000);
    step(1, 0, 0, 1, 32'h2000_0000);
    step(1, 1, 1, 0, 32'h0);
    check("sync_dds", dds, OFF);
    check("sync_wrap", {31'h0, wrap}, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f;
      f = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), f);
    end
    ftw_valid = 1'b0;

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 100) begin
      @(posedge clk);
      wait_cycles++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dds_phase_acc.md
DDS_PHASE_ACC -- requirements
Module: dds_phase_acc

Interface
REQ-001 SHALL have parameter PHASE_OFFSET, default 32'h0000_0000, phase loaded on reset and SYNC.
REQ-002 SHALL have parameter GLIDE_SHIFT, default 8, glide slew divisor exponent (range 1..16).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-005 SHALL have port ENABLE  input  1  sample tick; the phase advances only on cycles where it is high.
REQ-006 SHALL have port FTW_IN  input  32  frequency tuning word, unsigned.
REQ-007 SHALL have port FTW_VALID  input  1  FTW_IN valid.
REQ-008 SHALL have port FTW_READY  output  1  block can accept a tuning word.
REQ-009 SHALL have port SYNC  input  1  hard-sync request.
REQ-010 SHALL have port DDS  output  32  registered phase word, fed directly to the sine-table stage.
REQ-011 SHALL have port WRAP  output  1  registered one-cycle pulse marking phase overflow.

Function
REQ-012 SHALL hold cur_ftw (32b) as the active increment and, when PHASE_GLIDE_EN is defined, tgt_ftw (32b) as the glide target.
REQ-013 SHALL accept a word on a cycle where FTW_VALID and FTW_READY are both high, and SHALL ignore FTW_VALID while FTW_READY is low.
REQ-014 SHALL, on an ENABLE cycle without SYNC, register DDS <= (DDS + cur_ftw) mod 2^32 and WRAP <= carry-out of that add.
REQ-015 SHALL, on a non-ENABLE cycle without SYNC, hold DDS and drive WRAP low.
REQ-016 SHALL, when SYNC is high, register DDS <= PHASE_OFFSET and WRAP <= 0 regardless of ENABLE; SYNC has priority over increment.
REQ-017 SHALL use the pre-update cur_ftw for the increment when an accept or glide step coincides with ENABLE; the new value applies from the next ENABLE.
REQ-018 SHALL hold DDS constant with WRAP low when cur_ftw is 0.
REQ-019 SHALL latch the accepted FTW_IN into cur_ftw at the accept edge when glide is compiled out; FTW_READY is then constantly 1 outside reset.
REQ-020 SHALL have 1-cycle latency from ENABLE to the updated DDS and from SYNC to DDS = PHASE_OFFSET.

Reset
REQ-021 SHALL, while RESET is low at a clock edge, set DDS = PHASE_OFFSET, WRAP = 0, cur_ftw = 0, tgt_ftw = 0, state = IDLE and FTW_READY = 1; reset overrides SYNC, ENABLE and accept.
REQ-022 SHALL abort any glide in progress on reset, with no remnant of the old target.

Configuration
REQ-023 SHALL compile in glide (portamento) logic only when macro PHASE_GLIDE_EN is defined.
REQ-024 SHALL, with PHASE_GLIDE_EN defined, implement FSM IDLE/GLIDE: FTW_READY = (state == IDLE); an accept stores tgt_ftw <= FTW_IN and moves to GLIDE, leaving cur_ftw unchanged.
REQ-025 SHALL, in GLIDE on each ENABLE, compute diff = tgt_ftw - cur_ftw as 33-bit signed and step = diff >>> GLIDE_SHIFT; if step == 0 then cur_ftw <= tgt_ftw and state <= IDLE, else cur_ftw <= cur_ftw + step.
REQ-026 SHALL hold cur_ftw and state in GLIDE on non-ENABLE cycles; SYNC does not affect glide.
REQ-027 SHALL, without PHASE_GLIDE_EN, contain no FSM or tgt_ftw, and behave per REQ-019.

Verification
REQ-028 SHALL cover: reset, accept FTW 0x4000_0000, ENABLE held high -> DDS 0x0, 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0, with WRAP = 1 on the 0x0 cycle only.
REQ-029 SHALL cover: FTW 0x1000_0000 accepted in the same cycle as ENABLE with cur_ftw = 0 -> DDS unchanged that edge, then +0x1000_0000 on the next ENABLE.
REQ-030 SHALL cover: PHASE_OFFSET = 0x8000_0000, SYNC and ENABLE both high at DDS = 0xF000_0000 with FTW = 0x2000_0000 -> DDS = 0x8000_0000, WRAP = 0.
REQ-031 SHALL cover: ENABLE low for 5 cycles -> DDS constant, WRAP low throughout.
REQ-032 SHALL cover: PHASE_GLIDE_EN, GLIDE_SHIFT = 2, cur = 0, accept 16, ENABLE high -> cur_ftw 4, 7, 9, 10, 11, 12, 13, 16; FTW_READY low during the glide and high after the 8th tick; FTW_VALID ignored while low.
REQ-033 SHALL cover: RESET low mid-glide -> next edge FTW_READY = 1, cur_ftw = 0, DDS = PHASE_OFFSET, WRAP = 0.
